// File: rtl/alu_pkg.sv
// Shared CompALU definitions: funct codes, instruction field positions,
// expected-result tuple layout and the sequencer FSM encoding.
package alu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned RES_W   = 32;
    localparam int unsigned EXP_W   = RES_W + 2;

    // R-type funct codes understood by CompALU
    localparam logic [5:0] FUNCT_ADD = 6'd27;
    localparam logic [5:0] FUNCT_SUB = 6'd28;
    localparam logic [5:0] FUNCT_SRL = 6'd29;
    localparam logic [5:0] FUNCT_SLL = 6'd30;
    localparam logic [5:0] FUNCT_XOR = 6'd31;
    localparam logic [5:0] FUNCT_AND = 6'd32;

    // Instruction field bit positions
    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_MSB = 10;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    typedef struct packed {
        logic [RES_W-1:0] result;
        logic             zero;
        logic             carry;
    } exp_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        exp_t               expv;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Program-load, ALU and status bundle between the sequencer and its environment.
interface alu_instr_sequencer_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_instr;
    logic [33:0]   prog_exp;
    logic [LW-1:0] prog_len;
    logic          start;

    logic [31:0]   instr;
    logic [31:0]   alu_result;
    logic          alu_zero;
    logic          alu_carry;

    logic          busy;
    logic          done;
    logic [LW-1:0] err_cnt;
    logic [AW-1:0] first_err;
    logic [33:0]   last_obs;

    modport master (
        input  prog_we, prog_addr, prog_instr, prog_exp, prog_len, start,
        input  alu_result, alu_zero, alu_carry,
        output instr, busy, done, err_cnt, first_err, last_obs
    );

    modport slave (
        output prog_we, prog_addr, prog_instr, prog_exp, prog_len, start,
        output alu_result, alu_zero, alu_carry,
        input  instr, busy, done, err_cnt, first_err, last_obs
    );

endinterface

// File: rtl/seq_prog_mem.sv
// Program buffer: DEPTH entries of {instr, expected}, synchronous write,
// combinational read. Deliberately not reset so a reset keeps the program.
module seq_prog_mem
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata_c
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/alu_instr_sequencer.sv
// Self-checking instruction issuer for CompALU: plays the program buffer into
// the ALU one entry at a time and scores the results against expectations.
module alu_instr_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_instr_sequencer_if.master bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   instr_q, instr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [LW-1:0] err_cnt_q, err_cnt_d;
    logic [AW-1:0] first_err_q, first_err_d;
    exp_t          last_obs_q, last_obs_d;

    logic          mem_we_c;
    entry_t        wr_entry_c;
    entry_t        rd_entry_c;
    exp_t          obs_c;
    logic [LW-1:0] len_clamped_c;

    assign wr_entry_c    = {bus.prog_instr, bus.prog_exp};
    assign obs_c         = {bus.alu_result, bus.alu_zero, bus.alu_carry};
    assign len_clamped_c = (bus.prog_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.prog_len;

    seq_prog_mem #(
        .DEPTH (DEPTH)
    ) u_prog_mem (
        .clk     (clk),
        .we      (mem_we_c),
        .waddr   (bus.prog_addr),
        .wdata   (wr_entry_c),
        .raddr   (idx_q),
        .rdata_c (rd_entry_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        instr_d     = instr_q;
        done_d      = done_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        last_obs_d  = last_obs_q;
        mem_we_c    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                instr_d  = '0;
                mem_we_c = bus.prog_we;
                if (bus.start) begin
                    idx_d       = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    done_d      = 1'b0;
                    if (bus.prog_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        len_d   = len_clamped_c;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                instr_d = rd_entry_c.instr;
                cnt_d   = CW'(LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_CHECK: begin
                last_obs_d = obs_c;
                if (obs_c != rd_entry_c.expv) begin
                    if (err_cnt_q == '0) begin
                        first_err_d = idx_q;
                    end
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + LW'(1);
                    end
                end
                if ({1'b0, idx_q} == len_q - LW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                instr_d = '0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy tracks the state being entered so it is a clean flop output
        busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            instr_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            last_obs_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            instr_q     <= instr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            last_obs_q  <= last_obs_d;
        end
    end

    assign bus.instr     = instr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.first_err = first_err_q;
    assign bus.last_obs  = last_obs_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer with a small behavioural CompALU
// (fixed register values) answering the issued instructions.
module tb_alu_instr_sequencer;
    import alu_pkg::*;

    logic clk;
    logic rst_n;

    int n_chk;
    int n_pass;

    alu_instr_sequencer_if #(.DEPTH(16)) ifc ();

    alu_instr_sequencer #(
        .DEPTH (16),
        .LAT   (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file contents seen by the ALU model
    function automatic logic [31:0] reg_val(input logic [4:0] r);
        case (r)
            5'd1:    reg_val = 32'd44;
            5'd2:    reg_val = 32'd39;
            5'd3:    reg_val = 32'd43;
            5'd4:    reg_val = 32'd365;
            5'd5:    reg_val = 32'd92;
            5'd9:    reg_val = 32'd112;
            5'd11:   reg_val = 32'd2068;
            5'd21:   reg_val = 32'd112;
            default: reg_val = 32'd0;
        endcase
    endfunction

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [32:0] alu_wide;
    logic [4:0]  alu_sh;

    always_comb begin
        alu_a    = reg_val(ifc.instr[25:21]);
        alu_b    = reg_val(ifc.instr[20:16]);
        alu_sh   = ifc.instr[10:6];
        alu_wide = '0;
        case (ifc.instr[5:0])
            FUNCT_ADD: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            FUNCT_SUB: alu_wide = {(alu_a < alu_b), alu_a - alu_b};
            FUNCT_SRL: alu_wide = {1'b0, alu_b >> alu_sh};
            FUNCT_SLL: alu_wide = {1'b0, alu_b << alu_sh};
            FUNCT_XOR: alu_wide = {1'b0, alu_a ^ alu_b};
            FUNCT_AND: alu_wide = {1'b0, alu_a & alu_b};
            default:   alu_wide = '0;
        endcase
        ifc.alu_result = alu_wide[31:0];
        ifc.alu_carry  = alu_wide[32];
        ifc.alu_zero   = (alu_wide[31:0] == 32'd0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        rtype = {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [33:0] tup(input logic [31:0] r, input logic z, input logic c);
        tup = {r, z, c};
    endfunction

    task automatic prog(input logic [3:0] addr, input logic [31:0] ins, input logic [33:0] e);
        ifc.prog_we    = 1'b1;
        ifc.prog_addr  = addr;
        ifc.prog_instr = ins;
        ifc.prog_exp   = e;
        tick();
        ifc.prog_we    = 1'b0;
    endtask

    // Pulse start, then count cycles from the start edge until done rises
    task automatic run(input logic [4:0] len, output int cyc, output logic busy_seen,
                       output logic instr_nz, output logic [31:0] first_instr,
                       output logic done_at_start);
        ifc.prog_len  = len;
        ifc.start     = 1'b1;
        tick();
        ifc.start     = 1'b0;
        done_at_start = ifc.done;
        busy_seen     = ifc.busy;
        instr_nz      = (ifc.instr != 32'd0);
        first_instr   = 32'd0;
        cyc           = 0;
        while (!ifc.done && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == 1) first_instr = ifc.instr;
            if (ifc.busy) busy_seen = 1'b1;
            if (ifc.instr != 32'd0) instr_nz = 1'b1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_instr"},     64'(ifc.instr),     64'd0);
        chk({tag, "_busy"},      64'(ifc.busy),      64'd0);
        chk({tag, "_done"},      64'(ifc.done),      64'd0);
        chk({tag, "_err_cnt"},   64'(ifc.err_cnt),   64'd0);
        chk({tag, "_first_err"}, 64'(ifc.first_err), 64'd0);
        chk({tag, "_last_obs"},  64'(ifc.last_obs),  64'd0);
    endtask

    int          cyc;
    logic        busy_seen;
    logic        instr_nz;
    logic [31:0] first_instr;
    logic        done_at_start;

    initial begin
        n_chk          = 0;
        n_pass         = 0;
        rst_n          = 1'b0;
        ifc.prog_we    = 1'b0;
        ifc.prog_addr  = '0;
        ifc.prog_instr = '0;
        ifc.prog_exp   = '0;
        ifc.prog_len   = '0;
        ifc.start      = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // ADD 2068+112, SUB 2068-112
        prog(4'd0, rtype(5'd11, 5'd21, 5'd1, 5'd0, FUNCT_ADD), tup(32'd2180, 1'b0, 1'b0));
        prog(4'd1, rtype(5'd11, 5'd9,  5'd2, 5'd0, FUNCT_SUB), tup(32'd1956, 1'b0, 1'b0));
        run(5'd2, cyc, busy_seen, instr_nz, first_instr, done_at_start);
        chk("t1_cycles",      64'(cyc),          64'd7);
        chk("t1_first_instr", 64'(first_instr),  64'(rtype(5'd11, 5'd21, 5'd1, 5'd0, FUNCT_ADD)));
        chk("t1_err_cnt",     64'(ifc.err_cnt),  64'd0);
        chk("t1_last_obs",    64'(ifc.last_obs), 64'(tup(32'd1956, 1'b0, 1'b0)));
        chk("t1_busy_end",    64'(ifc.busy),     64'd0);
        chk("t1_instr_end",   64'(ifc.instr),    64'd0);

        // SUB r9,r9 -> zero flag
        prog(4'd0, rtype(5'd9, 5'd9, 5'd3, 5'd0, FUNCT_SUB), tup(32'd0, 1'b1, 1'b0));
        run(5'd1, cyc, busy_seen, instr_nz, first_instr, done_at_start);
        chk("t2_done_cleared", 64'(done_at_start), 64'd0);
        chk("t2_cycles",       64'(cyc),           64'd4);
        chk("t2_err_cnt",      64'(ifc.err_cnt),   64'd0);
        chk("t2_last_obs",     64'(ifc.last_obs),  64'(tup(32'd0, 1'b1, 1'b0)));

        // Shift/logic sequence, entry 2 deliberately expects 13 instead of 12
        prog(4'd0, rtype(5'd0, 5'd1, 5'd6, 5'd1, FUNCT_SRL), tup(32'd22,  1'b0, 1'b0));
        prog(4'd1, rtype(5'd0, 5'd1, 5'd7, 5'd2, FUNCT_SLL), tup(32'd176, 1'b0, 1'b0));
        prog(4'd2, rtype(5'd2, 5'd3, 5'd8, 5'd0, FUNCT_XOR), tup(32'd13,  1'b0, 1'b0));
        prog(4'd3, rtype(5'd4, 5'd5, 5'd9, 5'd0, FUNCT_AND), tup(32'd76,  1'b0, 1'b0));
        run(5'd4, cyc, busy_seen, instr_nz, first_instr, done_at_start);
        chk("t3_cycles",    64'(cyc),           64'd13);
        chk("t3_err_cnt",   64'(ifc.err_cnt),   64'd1);
        chk("t3_first_err", 64'(ifc.first_err), 64'd2);
        chk("t3_last_obs",  64'(ifc.last_obs),  64'(tup(32'd76, 1'b0, 1'b0)));

        // Zero-length run
        run(5'd0, cyc, busy_seen, instr_nz, first_instr, done_at_start);
        chk("t4_cycles",    64'(cyc),         64'd1);
        chk("t4_busy_seen", 64'(busy_seen),   64'd0);
        chk("t4_instr_nz",  64'(instr_nz),    64'd0);
        chk("t4_err_cnt",   64'(ifc.err_cnt), 64'd0);
        chk("t4_done",      64'(ifc.done),    64'd1);

        // Reset in WAIT of entry 1 with start/prog_we pulsed while busy
        ifc.prog_len = 5'd4;
        ifc.start    = 1'b1;
        tick();
        ifc.start = 1'b0;
        tick();
        tick();
        tick();
        ifc.start      = 1'b1;
        ifc.prog_we    = 1'b1;
        ifc.prog_addr  = 4'd2;
        ifc.prog_instr = rtype(5'd2, 5'd3, 5'd8, 5'd0, FUNCT_XOR);
        ifc.prog_exp   = tup(32'd12, 1'b0, 1'b0);
        tick();
        ifc.start   = 1'b0;
        ifc.prog_we = 1'b0;
        chk("t5_busy_before_rst", 64'(ifc.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t5_rst");
        tick();
        rst_n = 1'b1;
        tick();
        run(5'd4, cyc, busy_seen, instr_nz, first_instr, done_at_start);
        chk("t5_cycles",    64'(cyc),           64'd13);
        chk("t5_err_cnt",   64'(ifc.err_cnt),   64'd1);
        chk("t5_first_err", 64'(ifc.first_err), 64'd2);
        chk("t5_last_obs",  64'(ifc.last_obs),  64'(tup(32'd76, 1'b0, 1'b0)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
